// File: rtl/alu_unit_pkg.sv
// Shared processor definitions: ALU opcodes and ALU sequencer states.
// The control unit imports the same package to encode ALUOP.
package alu_unit_pkg;

  typedef enum logic [2:0] {
    OP_PASSB = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_MUL   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_INCA  = 3'b110,
    OP_CLR   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_unit_mul_seq.sv
// Iterative shift-add multiplier: one partial product per edge, MUL_CYCLES edges per multiply.
// done is high during the edge that retires the final iteration; product is valid alongside it.
module alu_mul_seq #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  logic               running;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;

  // Product includes the iteration being retired this edge, so the caller
  // can capture the result without an extra cycle.
  assign product = mplier[0] ? (acc + mcand) : acc;
  assign done    = running && (cnt == CW'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        running <= 1'b0;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// ALU with registered result/flags: single-cycle ops answer one edge after start, MUL after MUL_CYCLES more.
// No queueing: start is only accepted in IDLE; requests while busy or in DONE are dropped.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOP,
  input  logic [WIDTH-1:0] A_,
  input  logic [WIDTH-1:0] MUXOUT,
  output logic [WIDTH-1:0] ALUOUT,
  output logic             Z,
  output logic             C,
  output logic             busy,
  output logic             done
);

  alu_state_e         state;
  alu_op_e            op;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH-1:0]   res;
  logic               carry;
  logic [WIDTH:0]     wide;

  assign op        = alu_op_e'(ALUOP);
  assign mul_start = start && (state == IDLE) && (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (A_),
    .b       (MUXOUT),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    res   = '0;
    carry = 1'b0;
    wide  = '0;
    case (op)
      OP_PASSB: res = MUXOUT;
      OP_ADD: begin
        wide  = {1'b0, A_} + {1'b0, MUXOUT};
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_SUB: begin
        res   = A_ - MUXOUT;
        carry = (A_ < MUXOUT);
      end
      OP_AND:  res = A_ & MUXOUT;
      OP_OR:   res = A_ | MUXOUT;
      OP_INCA: begin
        wide  = {1'b0, A_} + (WIDTH+1)'(1);
        res   = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      default: res = '0;  // CLR, and MUL which retires through the multiplier
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ALUOUT <= '0;
      Z      <= 1'b1;
      C      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              state <= MUL;
              busy  <= 1'b1;
            end else begin
              ALUOUT <= res;
              Z      <= (res == '0);
              C      <= carry;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            ALUOUT <= mul_product[WIDTH-1:0];
            Z      <= (mul_product[WIDTH-1:0] == '0);
            C      <= |mul_product[2*WIDTH-1:WIDTH];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;  // DONE: one cycle, start dropped
      endcase
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: reset, arithmetic flags, multiplier timing, dropped starts, opcode sweep.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  ALUOP;
  logic [15:0] A_;
  logic [15:0] MUXOUT;
  logic [15:0] ALUOUT;
  logic        Z;
  logic        C;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  alu_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ALUOP  (ALUOP),
    .A_     (A_),
    .MUXOUT (MUXOUT),
    .ALUOUT (ALUOUT),
    .Z      (Z),
    .C      (C),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start cycle and returns 1 time unit after the start edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    start  = 1'b1;
    ALUOP  = op;
    A_     = a;
    MUXOUT = b;
    tick();
    start  = 1'b0;
  endtask

  // Issues an op and waits (bounded) until done is seen.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic got_done);
    issue(op, a, b);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
    end
    got_done = done;
  endtask

  // Reference: returns {Z, C, result}.
  function automatic logic [17:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [31:0] w;
    logic [15:0] r;
    logic        c;
    w = 32'd0;
    r = 16'd0;
    c = 1'b0;
    case (op)
      3'b000: r = b;
      3'b001: begin w = {16'd0, a} + {16'd0, b}; r = w[15:0]; c = w[16]; end
      3'b010: begin r = a - b; c = (a < b); end
      3'b011: begin w = {16'd0, a} * {16'd0, b}; r = w[15:0]; c = (w[31:16] != 16'd0); end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: begin r = a + 16'd1; c = (a == 16'hFFFF); end
      default: r = 16'd0;
    endcase
    return {(r == 16'd0), c, r};
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    ALUOP = 3'b110;
    A_    = 16'h1234;
    tick();
    checks++;
    if ({ALUOUT, Z, C, busy, done} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ALUOUT=%h Z=%b C=%b busy=%b done=%b, want 0000 1 0 0 0",
               ALUOUT, Z, C, busy, done);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if ({ALUOUT, done} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: ALUOUT=%h done=%b, want 0000 0", ALUOUT, done);
    end
  endtask

  task automatic test_add();
    issue(3'b001, 16'hFFFF, 16'h0001);
    checks++;
    if ({ALUOUT, Z, C, done, busy} !== {16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_wrap: ALUOUT=%h Z=%b C=%b done=%b busy=%b, want 0000 1 1 1 0",
               ALUOUT, Z, C, done, busy);
    end
    tick();
    checks++;
    if ({ALUOUT, Z, C, done} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_pulse: ALUOUT=%h Z=%b C=%b done=%b, want 0000 1 1 0",
               ALUOUT, Z, C, done);
    end
  endtask

  task automatic test_sub();
    issue(3'b010, 16'h0005, 16'h0007);
    checks++;
    if ({ALUOUT, Z, C, done} !== {16'hFFFE, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_borrow: ALUOUT=%h Z=%b C=%b done=%b, want fffe 0 1 1",
               ALUOUT, Z, C, done);
    end
    tick();
    issue(3'b010, 16'h0007, 16'h0007);
    checks++;
    if ({ALUOUT, Z, C, done} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal: ALUOUT=%h Z=%b C=%b done=%b, want 0000 1 0 1",
               ALUOUT, Z, C, done);
    end
    tick();
  endtask

  task automatic test_mul();
    int n;
    issue(3'b011, 16'h0012, 16'h0034);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mul_early_done: done=%b at busy cycle %0d, want 0", done, n);
      end
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL mul_busy_len: busy cycles=%0d, want 16", n);
    end
    checks++;
    if ({ALUOUT, Z, C, done} !== {16'h03A8, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_small: ALUOUT=%h Z=%b C=%b done=%b, want 03a8 0 0 1",
               ALUOUT, Z, C, done);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul_pulse: done=%b, want 0", done);
    end
    begin
      logic got;
      run_op(3'b011, 16'h1000, 16'h0010, got);
      checks++;
      if ({got, ALUOUT, Z, C} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL mul_overflow: done=%b ALUOUT=%h Z=%b C=%b, want 1 0000 1 1",
                 got, ALUOUT, Z, C);
      end
      tick();
    end
  endtask

  task automatic test_mul_start_ignored();
    int          pulses;
    logic [15:0] seen;
    pulses = 0;
    seen   = 16'hDEAD;
    issue(3'b011, 16'h0003, 16'h0005);
    for (int i = 0; i < 4; i++) tick();
    issue(3'b001, 16'hFFFF, 16'hFFFF);
    A_     = 16'hAAAA;
    MUXOUT = 16'h5555;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        seen = ALUOUT;
      end
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL mul_ignore_pulses: done pulses=%0d, want 1", pulses);
    end
    checks++;
    if (seen !== 16'h000F) begin
      errors++;
      $display("FAIL mul_ignore_result: ALUOUT=%h, want 000f", seen);
    end
  endtask

  task automatic test_done_drop();
    issue(3'b000, 16'h0000, 16'h1234);
    issue(3'b000, 16'h0000, 16'h5555);
    checks++;
    if ({ALUOUT, done} !== {16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL done_drop: ALUOUT=%h done=%b, want 1234 0", ALUOUT, done);
    end
    tick();
    checks++;
    if ({ALUOUT, done} !== {16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL done_drop_hold: ALUOUT=%h done=%b, want 1234 0", ALUOUT, done);
    end
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    logic got;
    issue(3'b011, 16'h0012, 16'h0034);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ALUOUT, Z, C, busy, done} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_abort: ALUOUT=%h Z=%b C=%b busy=%b done=%b, want 0000 1 0 0 0",
               ALUOUT, Z, C, busy, done);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mul_abort_quiet: done/busy cycles=%0d, want 0", pulses);
    end
    run_op(3'b000, 16'hFFFF, 16'h0FF0, got);
    checks++;
    if ({got, ALUOUT, Z, C} !== {1'b1, 16'h0FF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL passb_after_abort: done=%b ALUOUT=%h Z=%b C=%b, want 1 0ff0 0 0",
               got, ALUOUT, Z, C);
    end
    tick();
  endtask

  task automatic test_sweep();
    logic [15:0] a_tab [5];
    logic [15:0] b_tab [5];
    logic [17:0] exp;
    logic        got;
    a_tab = '{16'h00FF, 16'hFFFF, 16'h0F00, 16'h1234, 16'h0FF0};
    b_tab = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000, 16'h0FF0};
    for (int v = 0; v < 5; v++) begin
      for (int o = 0; o < 8; o++) begin
        exp = ref_alu(3'(o), a_tab[v], b_tab[v]);
        run_op(3'(o), a_tab[v], b_tab[v], got);
        checks++;
        if ({got, Z, C, ALUOUT} !== {1'b1, exp}) begin
          errors++;
          $display("FAIL sweep op=%0d a=%h b=%h: done=%b Z=%b C=%b ALUOUT=%h, want 1 %b %b %h",
                   o, a_tab[v], b_tab[v], got, Z, C, ALUOUT, exp[17], exp[16], exp[15:0]);
        end
        tick();
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    ALUOP  = 3'b000;
    A_     = 16'h0000;
    MUXOUT = 16'h0000;
    tick();
    tick();
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_mul_start_ignored();
    test_done_drop();
    test_reset_mid_mul();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath width of operands and result.
REQ-002 Parameter: MUL_CYCLES, WIDTH, iteration count of the shift-add multiplier.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  operation request, sampled each rising edge.
REQ-006 Port: ALUOP  input  3  operation code, sampled with start.
REQ-007 Port: A_  input  WIDTH  operand A (accumulator value).
REQ-008 Port: MUXOUT  input  WIDTH  operand B, driven by the ALU operand multiplexer.
REQ-009 Port: ALUOUT  output  WIDTH  registered result.
REQ-010 Port: Z  output  1  registered zero flag.
REQ-011 Port: C  output  1  registered carry/borrow flag.
REQ-012 Port: busy  output  1  high while a multi-cycle operation is in progress.
REQ-013 Port: done  output  1  one-cycle pulse when ALUOUT/Z/C are updated.

Function
REQ-014 Opcodes: 000 PASSB, 001 ADD, 010 SUB (A-B), 011 MUL, 100 AND, 101 OR, 110 INCA, 111 CLR.
REQ-015 States: IDLE, MUL, DONE; reset state IDLE.
REQ-016 IDLE with start=1 latches A_, MUXOUT, ALUOP in the same edge; IDLE with start=0 holds all outputs.
REQ-017 Single-cycle ops (all except MUL): result, Z, C written at the start edge; done=1 for the following cycle (latency 1); state goes to DONE then IDLE.
REQ-018 MUL: start edge enters MUL with busy=1; one shift-add iteration per edge; after MUL_CYCLES iterations ALUOUT = low WIDTH bits of A*B, state goes to DONE, busy=0, done=1 for one cycle.
REQ-019 ADD: {C,ALUOUT} = A+B, WIDTH+1-bit sum; C = carry out.
REQ-020 SUB: ALUOUT = A-B modulo 2^WIDTH; C = 1 when A < B (borrow).
REQ-021 INCA: ALUOUT = A+1; C = 1 only on wrap 0xFFFF -> 0x0000.
REQ-022 MUL: C = 1 when the upper WIDTH product bits are nonzero.
REQ-023 PASSB, AND, OR, CLR: C = 0.
REQ-024 Z = 1 exactly when the written ALUOUT is zero; Z and C change only when done is asserted.
REQ-025 start while busy=1 or in DONE is ignored (no queueing, no corruption of the operation in flight).
REQ-026 In DONE, state returns to IDLE on the next edge; a start asserted in that cycle is dropped.
REQ-027 Operand inputs changing during MUL have no effect on the result.
REQ-028 ALUOUT, Z, C hold their last written value indefinitely until the next done.

Reset
REQ-029 rst=1 at a rising edge forces: state IDLE, ALUOUT 0, Z 1, C 0, busy 0, done 0, iteration counter 0.
REQ-030 rst overrides start in the same edge; rst mid-MUL aborts the multiply with no done pulse.

Structure
REQ-031 Opcode constants and the state enumeration reside in the shared processor package, also used by the control unit.
REQ-032 One sub-module, alu_mul_seq, implements the iterative shift-add multiplier with start/done; everything else resides in alu_unit.

Verification
REQ-033 ADD: A_=0xFFFF, MUXOUT=0x0001, start 1 cycle -> next cycle ALUOUT=0x0000, Z=1, C=1, done=1 for exactly one cycle.
REQ-034 SUB: A_=0x0005, MUXOUT=0x0007 -> ALUOUT=0xFFFE, Z=0, C=1; A_=0x0007, MUXOUT=0x0007 -> ALUOUT=0x0000, Z=1, C=0.
REQ-035 MUL: A_=0x0012, MUXOUT=0x0034 -> busy=1 for 16 cycles, then ALUOUT=0x03A8, C=0, done pulse; A_=0x1000, MUXOUT=0x0010 -> ALUOUT=0x0000, Z=1, C=1.
REQ-036 MUL with start re-asserted and operands changed at cycle 5 -> start ignored, result unchanged, single done pulse.
REQ-037 rst asserted at cycle 8 of MUL -> next cycle ALUOUT=0, Z=1, busy=0, no done; subsequent PASSB with MUXOUT=0x0FF0 -> ALUOUT=0x0FF0.
REQ-038 Sweep all eight opcodes with MUXOUT values 0x000F, 0x00F0, 0x0F00, 0xF000, 0x0FF0 from the ALU operand multiplexer; compare against a reference model.
